serpent_de_core: RTL and testbench

SERPENT_DE_CORE -- requirements
Module: serpent_de_core

---
 rtl/serpent_pkg.sv | 70 +++++++
 rtl/serpent_de_round.sv | 27 ++
 rtl/serpent_de_core.sv | 115 +++++++++++
 tb/tb_serpent_de_core.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/serpent_pkg.sv
// Shared definitions for the Serpent decryption core: round/key constants,
// FSM state encoding, inverse S-box tables and the inverse linear transform.
// Word layout: X0 = block[31:0], X1 = [63:32], X2 = [95:64], X3 = [127:96];
// S-boxes are applied bitsliced, nibble {X3[j],X2[j],X1[j],X0[j]}.
package serpent_pkg;

  localparam int SERPENT_ROUNDS   = 32;
  localparam int SERPENT_LAST_KEY = 32;

  localparam logic [4:0] LAST_ROUND   = 5'(SERPENT_ROUNDS - 1);
  localparam logic [5:0] LAST_KEY_IDX = 6'(SERPENT_LAST_KEY);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_DONE  = 2'd2
  } fsm_e;

  // Inverse S-boxes, entry n of box b at INV_SBOX[b][4*n +: 4]; box 7 listed first.
  localparam logic [7:0][63:0] INV_SBOX = {
    64'h241A7BC58FE9D603,  // InvS7
    64'hB8C27E940635D1AF,  // InvS6
    64'h0AC7356BED1492F8,  // InvS5
    64'h1DF46BC2E79A3805,  // InvS4
    64'h1F842C53D6EB7A90,  // InvS3
    64'h7A85D63021EB4F9C,  // InvS2
    64'h0AD1974B3C6FE285,  // InvS1
    64'h289F74E1C56A0B3D   // InvS0
  };

  // Bitsliced application of inverse S-box 'box' across all 32 columns.
  function automatic logic [127:0] inv_sbox_slice(input logic [2:0] box, input logic [127:0] d);
    logic [63:0]  tbl;
    logic [3:0]   nib;
    logic [3:0]   o;
    logic [127:0] r;
    tbl = INV_SBOX[box];
    r   = 128'd0;
    for (int j = 0; j < 32; j++) begin
      nib       = {d[96+j], d[64+j], d[32+j], d[j]};
      o         = tbl[{nib, 2'b00} +: 4];
      r[j]      = o[0];
      r[32+j]   = o[1];
      r[64+j]   = o[2];
      r[96+j]   = o[3];
    end
    return r;
  endfunction

  // Undo the encryption linear transform, steps taken in reverse order.
  function automatic logic [127:0] inv_lt(input logic [127:0] d);
    logic [31:0] x0, x1, x2, x3;
    x0 = d[31:0];
    x1 = d[63:32];
    x2 = d[95:64];
    x3 = d[127:96];
    x2 = {x2[21:0], x2[31:22]};          // ror 22
    x0 = {x0[4:0],  x0[31:5]};           // ror 5
    x2 = x2 ^ x3 ^ {x1[24:0], 7'd0};
    x0 = x0 ^ x1 ^ x3;
    x3 = {x3[6:0],  x3[31:7]};           // ror 7
    x1 = {x1[0],    x1[31:1]};           // ror 1
    x3 = x3 ^ x2 ^ {x0[28:0], 3'd0};
    x1 = x1 ^ x0 ^ x2;
    x2 = {x2[2:0],  x2[31:3]};           // ror 3
    x0 = {x0[12:0], x0[31:13]};          // ror 13
    return {x3, x2, x1, x0};
  endfunction

endpackage

// File: rtl/serpent_de_round.sv
// One combinational Serpent inverse round:
//   o_data = InvS[round mod 8](InvLT(i_data)) ^ i_subkey,
// with InvLT bypassed for round 31 (the final encryption round has no LT).
module serpent_de_round
  import serpent_pkg::*;
(
  input  logic [127:0] i_data,
  input  logic [127:0] i_subkey,
  input  logic [4:0]   i_round,
  output logic [127:0] o_data
);

  logic [127:0] w_pre;
  logic [127:0] w_sbox;

  // Inverse linear transform (skipped on the last round), inverse S-box, key mix.
  always_comb begin
    if (i_round == LAST_ROUND) begin
      w_pre = i_data;
    end else begin
      w_pre = inv_lt(i_data);
    end
    w_sbox = inv_sbox_slice(i_round[2:0], w_pre);
    o_data = w_sbox ^ i_subkey;
  end

endmodule

// File: rtl/serpent_de_core.sv
// Iterative Serpent block decryption core: one inverse round per clock,
// 32 rounds, K32 whitening on accept. Subkeys are fetched externally via
// o_subkey_idx / i_subkey in the same cycle.
// Optional feature macro: SERPENT_DE_ZEROIZE_EN -- clears the state register
// when the plaintext is handed off and masks o_data outside DONE.
module serpent_de_core
  import serpent_pkg::*;
(
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [127:0] i_data,
  output logic [5:0]   o_subkey_idx,
  input  logic [127:0] i_subkey,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [127:0] o_data
);

  fsm_e         r_fsm;
  fsm_e         w_fsm_next;
  logic [4:0]   r_cnt;
  logic [4:0]   w_cnt_next;
  logic [127:0] r_state;
  logic [127:0] w_state_next;
  logic [127:0] w_round_out;

  serpent_de_round u_round (
    .i_data   (r_state),
    .i_subkey (i_subkey),
    .i_round  (r_cnt),
    .o_data   (w_round_out)
  );

  // State register, round counter and datapath register; reset wins over all.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_fsm   <= ST_IDLE;
      r_cnt   <= LAST_ROUND;
      r_state <= 128'd0;
    end else begin
      r_fsm   <= w_fsm_next;
      r_cnt   <= w_cnt_next;
      r_state <= w_state_next;
    end
  end

  // Next-state logic: accept with whitening, iterate rounds, hold result until taken.
  always_comb begin
    w_fsm_next   = r_fsm;
    w_cnt_next   = r_cnt;
    w_state_next = r_state;
    case (r_fsm)
      ST_IDLE: begin
        if (i_valid) begin
          w_state_next = i_data ^ i_subkey;
          w_cnt_next   = LAST_ROUND;
          w_fsm_next   = ST_ROUND;
        end else begin
          w_fsm_next   = ST_IDLE;
        end
      end
      ST_ROUND: begin
        w_state_next = w_round_out;
        if (r_cnt == 5'd0) begin
          w_fsm_next = ST_DONE;
        end else begin
          w_cnt_next = r_cnt - 5'd1;
        end
      end
      ST_DONE: begin
        if (i_ready) begin
          w_fsm_next = ST_IDLE;
`ifdef SERPENT_DE_ZEROIZE_EN
          w_state_next = 128'd0;
`endif
        end else begin
          w_fsm_next = ST_DONE;
        end
      end
      default: begin
        w_fsm_next = ST_IDLE;
      end
    endcase
  end

  // Output decode from the registered FSM state and datapath.
  always_comb begin
    o_ready      = 1'b0;
    o_valid      = 1'b0;
    o_subkey_idx = LAST_KEY_IDX;
`ifdef SERPENT_DE_ZEROIZE_EN
    o_data       = 128'd0;
`else
    o_data       = r_state;
`endif
    case (r_fsm)
      ST_IDLE: begin
        o_ready = 1'b1;
      end
      ST_ROUND: begin
        o_subkey_idx = {1'b0, r_cnt};
      end
      ST_DONE: begin
        o_valid = 1'b1;
        o_data  = r_state;
      end
      default: begin
        o_ready = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_serpent_de_core.sv
// Directed bench for serpent_de_core. Ciphertexts come from a forward
// Serpent model (S0..S7 + LT) with subkeys K[i] = {4{base + i}}.
module tb_serpent_de_core;

  logic         i_clk = 1'b0;
  logic         i_rst;
  logic         i_valid;
  logic         o_ready;
  logic [127:0] i_data;
  logic [5:0]   o_subkey_idx;
  logic [127:0] i_subkey;
  logic         o_valid;
  logic         i_ready;
  logic [127:0] o_data;

  logic [31:0]  key_base;
  int           n_chk  = 0;
  int           n_pass = 0;

  assign i_subkey = {4{key_base + {26'd0, o_subkey_idx}}};

  serpent_de_core dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_valid      (i_valid),
    .o_ready      (o_ready),
    .i_data       (i_data),
    .o_subkey_idx (o_subkey_idx),
    .i_subkey     (i_subkey),
    .o_valid      (o_valid),
    .i_ready      (i_ready),
    .o_data       (o_data)
  );

  always #5 i_clk = ~i_clk;

  int FWD [8][16] = '{
    '{ 3, 8,15, 1,10, 6, 5,11,14,13, 4, 2, 7, 0, 9,12},
    '{15,12, 2, 7, 9, 0, 5,10, 1,11,14, 8, 6,13, 3, 4},
    '{ 8, 6, 7, 9, 3,12,10,15,13, 1,14, 4, 0,11, 5, 2},
    '{ 0,15,11, 8,12, 9, 6, 3,13, 1, 2, 4,10, 7, 5,14},
    '{ 1,15, 8, 3,12, 0,11, 6, 2, 5, 4,10, 9,14, 7,13},
    '{15, 5, 2,11, 4,10, 9,12, 0, 3,14, 8,13, 6, 7, 1},
    '{ 7, 2,12, 5, 8, 4, 6,11,14, 9, 1,15,13, 3,10, 0},
    '{ 1,13,15, 0,14, 8, 2,11, 7, 4,12,10, 9, 3, 5, 6}
  };

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [127:0] fwd_sbox(input int b, input logic [127:0] s);
    logic [127:0] r;
    int           nib;
    int           o;
    r = 128'd0;
    for (int j = 0; j < 32; j++) begin
      nib = 8 * int'(s[96+j]) + 4 * int'(s[64+j]) + 2 * int'(s[32+j]) + int'(s[j]);
      o   = FWD[b][nib];
      r[j]    = o[0];
      r[32+j] = o[1];
      r[64+j] = o[2];
      r[96+j] = o[3];
    end
    return r;
  endfunction

  function automatic logic [127:0] fwd_lt(input logic [127:0] s);
    logic [31:0] x0, x1, x2, x3;
    x0 = s[31:0]; x1 = s[63:32]; x2 = s[95:64]; x3 = s[127:96];
    x0 = rotl(x0, 13);
    x2 = rotl(x2, 3);
    x1 = x1 ^ x0 ^ x2;
    x3 = x3 ^ x2 ^ (x0 << 3);
    x1 = rotl(x1, 1);
    x3 = rotl(x3, 7);
    x0 = x0 ^ x1 ^ x3;
    x2 = x2 ^ x3 ^ (x1 << 7);
    x0 = rotl(x0, 5);
    x2 = rotl(x2, 22);
    return {x3, x2, x1, x0};
  endfunction

  function automatic logic [127:0] encrypt(input logic [127:0] pt, input logic [31:0] base);
    logic [127:0] s;
    s = pt;
    for (int r = 0; r < 32; r++) begin
      s = s ^ {4{base + 32'(r)}};
      s = fwd_sbox(r % 8, s);
      if (r < 31) s = fwd_lt(s);
    end
    return s ^ {4{base + 32'd32}};
  endfunction

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // Offer a block from IDLE; it is taken on the next edge.
  task automatic accept(input logic [127:0] ct);
    check("accept_ready", 128'(o_ready), 128'd1);
    check("accept_idx", 128'(o_subkey_idx), 128'd32);
    i_valid = 1'b1;
    i_data  = ct;
    step();
    i_valid = 1'b0;
    i_data  = 128'd0;
  endtask

  // Walk the 32 round cycles, optionally offering a junk block every cycle.
  task automatic rounds(input logic jam);
    for (int k = 31; k >= 0; k--) begin
      check("round_idx", 128'(o_subkey_idx), 128'(k));
      check("round_ready", 128'(o_ready), 128'd0);
      check("round_valid", 128'(o_valid), 128'd0);
      if (jam) begin
        i_valid = 1'b1;
        i_data  = 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF;
      end
      step();
    end
    i_valid = 1'b0;
    i_data  = 128'd0;
  endtask

  // DONE phase: hold under backpressure, then hand off (optionally with a next block offered).
  task automatic finish(input logic [127:0] pt, input int hold, input logic nv, input logic [127:0] nct);
    logic [127:0] zexp;
`ifdef SERPENT_DE_ZEROIZE_EN
    zexp = 128'd0;
`else
    zexp = pt;
`endif
    check("done_valid", 128'(o_valid), 128'd1);
    check("done_data", o_data, pt);
    i_ready = 1'b0;
    for (int h = 0; h < hold; h++) begin
      step();
      check("hold_valid", 128'(o_valid), 128'd1);
      check("hold_data", o_data, pt);
    end
    i_ready = 1'b1;
    if (nv) begin
      i_valid = 1'b1;
      i_data  = nct;
    end
    step();
    i_ready = 1'b0;
    check("post_ready", 128'(o_ready), 128'd1);
    check("post_valid", 128'(o_valid), 128'd0);
    check("post_data", o_data, zexp);
  endtask

  initial begin
    logic [127:0] pt1, pt2, pt3, pt4, ct1, ct2, ct3, ct4;
    i_rst    = 1'b1;
    i_valid  = 1'b0;
    i_data   = 128'd0;
    i_ready  = 1'b0;
    key_base = 32'h9E3779B9;

    pt1 = 128'h00112233445566778899AABBCCDDEEFF;
    pt2 = {128{1'b1}};
    pt3 = 128'd0;
    pt4 = 128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0;
    ct1 = encrypt(pt1, 32'h9E3779B9);
    ct2 = encrypt(pt2, 32'h9E3779B9);
    ct3 = encrypt(pt3, 32'h01234567);
    ct4 = encrypt(pt4, 32'h01234567);

    step();
    step();
    check("rst_ready", 128'(o_ready), 128'd1);
    check("rst_valid", 128'(o_valid), 128'd0);
    check("rst_data", o_data, 128'd0);
    check("rst_idx", 128'(o_subkey_idx), 128'd32);

    // Reset held together with a valid block: nothing is accepted.
    i_valid = 1'b1;
    i_data  = ct1;
    step();
    check("rstprio_ready", 128'(o_ready), 128'd1);
    check("rstprio_idx", 128'(o_subkey_idx), 128'd32);
    i_rst   = 1'b0;
    i_valid = 1'b0;
    i_data  = 128'd0;
    step();

    // Round trip with 10 cycles of backpressure; next block offered on the DONE handshake.
    accept(ct1);
    rounds(1'b0);
    finish(pt1, 10, 1'b1, ct2);

    // Block still offered in the new IDLE cycle is taken now; junk offered while busy.
    accept(ct2);
    rounds(1'b1);
    finish(pt2, 0, 1'b0, 128'd0);

    // Reset mid-operation at subkey index 15.
    key_base = 32'h01234567;
    accept(ct3);
    for (int c = 0; c < 16; c++) step();
    check("mid_idx", 128'(o_subkey_idx), 128'd15);
    i_rst = 1'b1;
    step();
    i_rst = 1'b0;
    check("midrst_ready", 128'(o_ready), 128'd1);
    check("midrst_valid", 128'(o_valid), 128'd0);
    check("midrst_data", o_data, 128'd0);

    // Fresh block after the aborted one.
    accept(ct4);
    rounds(1'b0);
    finish(pt4, 0, 1'b0, 128'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
